// File: rtl/vip_dscale2x_pkg.sv
// Shared types and constants for the 2x2 box downscaler.
// Counter widths come from CLOG2; pipeline depth is fixed so bypass and downscale line up.
package vip_dscale2x_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    EVEN_LINE  = 2'd1,
    ODD_LINE   = 2'd2
  } state_t;

  localparam int DSCALE2X_LAT = 3;

  function automatic int CLOG2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vip_dscale2x_if.sv
// href/vsync/RGB video stream bundle; the source drives every signal and the sink only observes.
// The stream carries no backpressure, so the sink must accept a pixel on every active href cycle.
interface vip_dscale2x_if #(
  parameter int BITS = 8
);
  logic            href;
  logic            vsync;
  logic [BITS-1:0] data_r;
  logic [BITS-1:0] data_g;
  logic [BITS-1:0] data_b;

  modport master (output href, vsync, data_r, data_g, data_b);
  modport slave  (input  href, vsync, data_r, data_g, data_b);
endinterface

// File: rtl/vip_dscale2x_linebuf.sv
// Simple dual-port line store with one-cycle registered read.
// Single clock, no reset; contents persist and are always rewritten before being read.
module vip_dscale2x_linebuf #(
  parameter int DW    = 27,
  parameter int DEPTH = 640,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdat,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdat
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdat;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    if (i_re) r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/vip_dscale2x.sv
// 2:1 x 2:1 RGB box downscaler with runtime bypass; output is 3 pclk behind the input in both modes.
// No backpressure: one pixel is consumed per active href cycle and out_href pulses once per 2x2 block.
module vip_dscale2x
  import vip_dscale2x_pkg::*;
#(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960
) (
  input  logic             i_pclk,
  input  logic             i_rst,
  input  logic             i_enable,
  vip_dscale2x_if.slave    i_vid,
  vip_dscale2x_if.master   o_vid
);

  localparam int LAT   = DSCALE2X_LAT;
  localparam int XW    = CLOG2(WIDTH + 1);
  localparam int YW    = CLOG2(HEIGHT + 1);
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = CLOG2(DEPTH);
  localparam int HW    = BITS + 1;
  localparam int DW    = 3 * HW;
  localparam int PW    = 3 * BITS;
  localparam logic [XW-1:0]   XMAX = XW'(WIDTH);
  localparam logic [YW-1:0]   YMAX = YW'(HEIGHT);
  localparam logic [BITS+1:0] RND  = (BITS + 2)'(2);

  state_t          r_state, w_state, w_state_nxt;
  logic            r_enable, w_en;
  logic            r_href_d, r_vsync_d;
  logic [XW-1:0]   r_x, w_x, w_x_nxt;
  logic [YW-1:0]   r_y, w_y, w_y_nxt;
  logic [BITS-1:0] r_prev_r, r_prev_g, r_prev_b;

  logic w_fs, w_vrise, w_hrise, w_hfall, w_in_frame, w_pix;
  logic w_lb_we, w_lb_re;
  logic [AW-1:0] w_lb_addr;
  logic [DW-1:0] w_lb_wdat, w_lb_q;
  logic [HW-1:0] w_hs_r, w_hs_g, w_hs_b, w_lq_r, w_lq_g, w_lq_b;
  logic [BITS-1:0] w_avg_r, w_avg_g, w_avg_b;
  logic          w_out_vld;
  logic [PW-1:0] w_out_dat;

  logic          r_p_vld [LAT];
  logic          r_p_vs  [LAT];
  logic [PW-1:0] r_p_dat [LAT];

  assign w_fs    =  r_vsync_d & ~i_vid.vsync;
  assign w_vrise = ~r_vsync_d &  i_vid.vsync;
  assign w_hrise = ~r_href_d  &  i_vid.href;
  assign w_hfall =  r_href_d  & ~i_vid.href;

  // The w_* values describe the cycle being sampled, so a frame start and line start
  // arriving together both land on the very first pixel.
  always_comb begin
    w_state = r_state;
    if (w_vrise)   w_state = WAIT_FRAME;
    else if (w_fs) w_state = EVEN_LINE;
    w_en = w_fs ? i_enable : r_enable;
    w_x  = (w_fs | w_hrise) ? '0 : r_x;
    w_y  = w_fs ? '0 : r_y;

    w_state_nxt = w_state;
    w_x_nxt     = w_x;
    w_y_nxt     = w_y;
    if (w_hfall) begin
      w_x_nxt = '0;
      w_y_nxt = (w_y == YMAX) ? w_y : w_y + 1'b1;
      if (w_state == EVEN_LINE)     w_state_nxt = ODD_LINE;
      else if (w_state == ODD_LINE) w_state_nxt = EVEN_LINE;
    end else if (i_vid.href) begin
      w_x_nxt = (w_x == XMAX) ? w_x : w_x + 1'b1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_state   <= WAIT_FRAME;
      r_enable  <= 1'b0;
      r_href_d  <= 1'b0;
      r_vsync_d <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_enable  <= w_en;
      r_href_d  <= i_vid.href;
      r_vsync_d <= i_vid.vsync;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
    end
  end

  assign w_in_frame = (w_state != WAIT_FRAME);
  assign w_pix      = i_vid.href & w_in_frame & (w_x < XMAX) & (w_y < YMAX);
  assign w_lb_we    = w_pix & w_en & (w_state == EVEN_LINE) &  w_x[0];
  assign w_lb_re    = w_pix & w_en & (w_state == ODD_LINE)  & ~w_x[0];
  assign w_lb_addr  = w_x[AW:1];

  always_ff @(posedge i_pclk) begin
    if (w_pix) begin
      r_prev_r <= i_vid.data_r;
      r_prev_g <= i_vid.data_g;
      r_prev_b <= i_vid.data_b;
    end
  end

  assign w_hs_r    = {1'b0, r_prev_r} + {1'b0, i_vid.data_r};
  assign w_hs_g    = {1'b0, r_prev_g} + {1'b0, i_vid.data_g};
  assign w_hs_b    = {1'b0, r_prev_b} + {1'b0, i_vid.data_b};
  assign w_lb_wdat = {w_hs_r, w_hs_g, w_hs_b};

  vip_dscale2x_linebuf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_linebuf (
    .i_clk   (i_pclk),
    .i_we    (w_lb_we),
    .i_waddr (w_lb_addr),
    .i_wdat  (w_lb_wdat),
    .i_re    (w_lb_re),
    .i_raddr (w_lb_addr),
    .o_rdat  (w_lb_q)
  );

  assign w_lq_r = w_lb_q[3*HW-1 -: HW];
  assign w_lq_g = w_lb_q[2*HW-1 -: HW];
  assign w_lq_b = w_lb_q[HW-1:0];

  // Worst case 4*max+2 still fits in BITS+2, so the rounded average never saturates.
  assign w_avg_r = BITS'(({1'b0, w_lq_r} + {1'b0, w_hs_r} + RND) >> 2);
  assign w_avg_g = BITS'(({1'b0, w_lq_g} + {1'b0, w_hs_g} + RND) >> 2);
  assign w_avg_b = BITS'(({1'b0, w_lq_b} + {1'b0, w_hs_b} + RND) >> 2);

  assign w_out_vld = w_en ? (w_pix & (w_state == ODD_LINE) & w_x[0])
                          : (i_vid.href & w_in_frame);
  assign w_out_dat = !w_out_vld ? '0 :
                     w_en ? {w_avg_r, w_avg_g, w_avg_b}
                          : {i_vid.data_r, i_vid.data_g, i_vid.data_b};

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_p_vld[i] <= 1'b0;
        r_p_vs[i]  <= 1'b0;
        r_p_dat[i] <= '0;
      end
    end else begin
      r_p_vld[0] <= w_out_vld;
      r_p_vs[0]  <= i_vid.vsync;
      r_p_dat[0] <= w_out_dat;
      for (int i = 1; i < LAT; i++) begin
        r_p_vld[i] <= r_p_vld[i-1];
        r_p_vs[i]  <= r_p_vs[i-1];
        r_p_dat[i] <= r_p_dat[i-1];
      end
    end
  end

  assign o_vid.href   = r_p_vld[LAT-1];
  assign o_vid.vsync  = r_p_vs[LAT-1];
  assign o_vid.data_r = r_p_dat[LAT-1][3*BITS-1 -: BITS];
  assign o_vid.data_g = r_p_dat[LAT-1][2*BITS-1 -: BITS];
  assign o_vid.data_b = r_p_dat[LAT-1][BITS-1:0];

endmodule

// File: tb/tb_vip_dscale2x.sv
// Directed bench for vip_dscale2x at WIDTH=8: hand-computed 2x2 averages, bypass timing and boundaries.
module tb_vip_dscale2x;

  localparam int BITS = 8;
  localparam int W    = 8;
  localparam int H    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  vip_dscale2x_if #(.BITS(BITS)) vin ();
  vip_dscale2x_if #(.BITS(BITS)) vout ();

  vip_dscale2x #(.BITS(BITS), .WIDTH(W), .HEIGHT(H)) dut (
    .i_pclk   (clk),
    .i_rst    (rst),
    .i_enable (enable),
    .i_vid    (vin.slave),
    .o_vid    (vout.master)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [23:0] q_dat[$];
  int          q_cyc[$];
  int          drv[16][16];
  int          vs_err = 0, zero_err = 0, bad_wr = 0, since_rst = 0;
  logic [2:0]  vs_h = 3'b0;

  always @(negedge clk) begin
    if (vout.href) begin
      q_dat.push_back({vout.data_r, vout.data_g, vout.data_b});
      q_cyc.push_back(cyc);
    end else if ({vout.data_r, vout.data_g, vout.data_b} !== 24'h0) begin
      zero_err++;
    end
    if (rst) since_rst = 0;
    else if (since_rst < 100) since_rst++;
    if (since_rst >= 4 && vout.vsync !== vs_h[2]) vs_err++;
    vs_h = {vs_h[1:0], vin.vsync};
    if (dut.w_lb_we && dut.w_x >= W) bad_wr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_px(input string tag, input int i, input logic [23:0] e, input int ecyc);
    logic [31:0] d, c;
    d = (i < q_dat.size()) ? {8'h0, q_dat[i]} : 32'hxxxxxxxx;
    c = (i < q_cyc.size()) ? q_cyc[i] : 32'hxxxxxxxx;
    check({tag, "_dat"}, d, {8'h0, e});
    check({tag, "_cyc"}, c, ecyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic href, input logic vs, input logic [23:0] d);
    vin.href  = href;
    vin.vsync = vs;
    {vin.data_r, vin.data_g, vin.data_b} = d;
    step();
  endtask

  function automatic logic [23:0] pix(input int pat, input int x, input int y);
    logic [7:0] v;
    case (pat)
      0: begin v = 8'(10 * (x + 1) + y); return {v, v, v}; end
      1: return 24'hFFFFFF;
      3: begin v = 8'(x + 10 * y); return {v, 8'(v + 100), 8'(250 - v)}; end
      4: begin v = 8'(x + 8 * y);  return {v, 8'(v + 64), 8'(v + 128)}; end
      5: begin v = 8'(x + 16 * y); return {v, v, v}; end
      default: return 24'h0;
    endcase
  endfunction

  task automatic run_frame(input int w, input int h, input int pat, input logic en,
                           input int flip_y, input int rst_y, input int rst_x, input bit same_edge);
    q_dat.delete();
    q_cyc.delete();
    enable = en;
    repeat (4) drive(1'b0, 1'b1, 24'h0);
    if (!same_edge) repeat (2) drive(1'b0, 1'b0, 24'h0);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (y == flip_y && x == 0) enable = ~en;
        rst = (y == rst_y && x == rst_x);
        drv[y][x] = cyc;
        drive(1'b1, 1'b0, pix(pat, x, y));
        if (rst) check("rst_clears_out", {7'h0, vout.href, vout.data_r, vout.data_g, vout.data_b}, 32'h0);
      end
      rst = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 24'h0);
    end
    repeat (3) drive(1'b0, 1'b0, 24'h0);
    repeat (4) drive(1'b0, 1'b1, 24'h0);
  endtask

  initial begin
    int tab[8] = '{5, 7, 9, 11, 21, 23, 25, 27};
    logic [7:0] a;
    vin.href = 1'b0; vin.vsync = 1'b0;
    {vin.data_r, vin.data_g, vin.data_b} = 24'h0;
    repeat (3) step();
    check("reset_href",  {31'h0, vout.href}, 32'h0);
    check("reset_vsync", {31'h0, vout.vsync}, 32'h0);
    check("reset_data",  {8'h0, vout.data_r, vout.data_g, vout.data_b}, 32'h0);
    rst = 1'b0;

    // href with no frame start seen since reset must be ignored, even in bypass
    q_dat.delete(); q_cyc.delete();
    repeat (4) drive(1'b1, 1'b0, 24'h123456);
    repeat (6) drive(1'b0, 1'b0, 24'h0);
    check("wait_frame_ignored", q_dat.size(), 0);

    // 1: 4x2, vsync fall coincides with the first href rise
    run_frame(4, 2, 0, 1'b1, -1, -1, -1, 1'b1);
    check("t1_count", q_dat.size(), 2);
    check_px("t1_p0", 0, {3{8'd16}}, drv[1][1] + 3);
    check_px("t1_p1", 1, {3{8'd36}}, drv[1][3] + 3);

    // 2: full scale then zero
    run_frame(4, 2, 1, 1'b1, -1, -1, -1, 1'b0);
    check("t2a_count", q_dat.size(), 2);
    check_px("t2a_p0", 0, 24'hFFFFFF, drv[1][1] + 3);
    check_px("t2a_p1", 1, 24'hFFFFFF, drv[1][3] + 3);
    run_frame(4, 2, 2, 1'b1, -1, -1, -1, 1'b0);
    check("t2b_count", q_dat.size(), 2);
    check_px("t2b_p0", 0, 24'h000000, drv[1][1] + 3);
    check_px("t2b_p1", 1, 24'h000000, drv[1][3] + 3);

    // 3: odd geometry 5x3, distinct channels
    run_frame(5, 3, 3, 1'b1, -1, -1, -1, 1'b0);
    check("t3_count", q_dat.size(), 2);
    check_px("t3_p0", 0, {8'd6, 8'd106, 8'd245}, drv[1][1] + 3);
    check_px("t3_p1", 1, {8'd8, 8'd108, 8'd243}, drv[1][3] + 3);

    // 4: bypass 8x4 with enable raised before row 2, then a downscaled frame
    run_frame(8, 4, 4, 1'b0, 2, -1, -1, 1'b0);
    check("t4_bypass_count", q_dat.size(), 32);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        check_px("t4_bypass", y * 8 + x, pix(4, x, y), drv[y][x] + 3);
    run_frame(8, 4, 4, 1'b1, -1, -1, -1, 1'b0);
    check("t4_scale_count", q_dat.size(), 8);
    for (int i = 0; i < 8; i++) begin
      a = 8'(tab[i]);
      check_px("t4_scale", i, {a, 8'(a + 64), 8'(a + 128)}, drv[2 * (i / 4) + 1][2 * (i % 4) + 1] + 3);
    end

    // 5: reset while the first average is in flight, then a clean frame
    run_frame(4, 2, 0, 1'b1, -1, 1, 2, 1'b0);
    check("t5_rst_count", q_dat.size(), 0);
    run_frame(4, 2, 0, 1'b1, -1, -1, -1, 1'b0);
    check("t5_after_count", q_dat.size(), 2);
    check_px("t5_p0", 0, {3{8'd16}}, drv[1][1] + 3);
    check_px("t5_p1", 1, {3{8'd36}}, drv[1][3] + 3);

    // 6: over-wide lines; sums of 4x+34 exercise round-half-up
    run_frame(W + 4, 2, 5, 1'b1, -1, -1, -1, 1'b0);
    check("t6_count", q_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = 8'(2 * i + 9);
      check_px("t6", i, {a, a, a}, drv[1][2 * i + 1] + 3);
    end

    check("lb_write_addr_range", bad_wr, 0);
    check("vsync_delay3", vs_err, 0);
    check("idle_data_zero", zero_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vip_dscale2x.md
Name: vip_dscale2x

Overview:
- 2:1 horizontal and 2:1 vertical RGB box downscaler (2x2 average, round-half-up).
- Sits directly downstream of the on-screen-display stage and consumes its href/vsync/RGB stream; feeds the output/packing stage.
- Runtime bypass passes full-resolution video with identical latency.

Parameters:
BITS, 8, bits per colour channel
WIDTH, 1280, max input active width (pixels); line buffer holds WIDTH/2 entries
HEIGHT, 960, max input active height (lines)

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous, active-high reset
enable  in  1  1 = downscale, 0 = bypass; sampled at frame start only
in_href  in  1  input line-active qualifier
in_vsync  in  1  input frame sync; high in vertical blanking, falling edge = frame start
in_data_r / in_data_g / in_data_b  in  BITS each  input pixel
out_href  out  1  output pixel-valid strobe (in bypass, equals delayed in_href)
out_vsync  out  1  in_vsync delayed 3 cycles
out_data_r / out_data_g / out_data_b  out  BITS each  output pixel; 0 whenever out_href = 0

Behaviour:
- Reset: all outputs 0, counters 0, state WAIT_FRAME, enable_r = 0.
- Frame start is a falling edge of in_vsync (registered compare):
  - enable_r <= enable.
  - x and y counters cleared.
  - State -> EVEN_LINE.
- A rising edge of in_vsync forces state WAIT_FRAME.
- Reset mid-frame: no pixel is processed until the next frame start.
- State machine WAIT_FRAME / EVEN_LINE / ODD_LINE:
  - A falling edge of in_href toggles EVEN_LINE <-> ODD_LINE, increments y and clears x.
  - A rising edge of in_href clears x.
  - When the in_vsync falling edge and the in_href rising edge occur in the same cycle, both actions apply.
- Pair sum: at odd x, for each channel, hsum = pixel[x-1] + pixel[x], width BITS+1.
- EVEN_LINE, odd x: hsum for all 3 channels is written to the line buffer at address x>>1. No output.
- ODD_LINE:
  - Read address x>>1 is issued at even x, so the registered read data is ready at odd x.
  - At odd x: sum = lb + hsum (BITS+2 bits). out = (sum + 2) >> 2, truncated to BITS; maximum 4*(2^BITS-1)+2 fits, so no saturation is needed.
  - out_href is strobed 1 cycle per output pixel, so it is non-contiguous: one pulse every 2 input pixels.
- Latency:
  - Downscale: the output appears exactly 3 pclk after the odd-x, odd-line input pixel is presented.
  - Bypass: out_href/out_data equal in_href/in_data delayed 3 cycles.
  - out_vsync is always in_vsync delayed 3 cycles.
- Boundaries:
  - Odd active width: the last unpaired pixel is dropped (no write, no output).
  - Odd active height: the last line is dropped.
  - Pixels with x >= WIDTH and lines with y >= HEIGHT are ignored.
  - WAIT_FRAME: in_href is ignored (no writes, out_href = 0, except in bypass, which is gated only by being in a frame).
- enable changes mid-frame take effect at the next frame start.
- The line buffer is never cleared. Every ODD_LINE read hits an entry written by the immediately preceding EVEN_LINE.

Decomposition:
- Shared package (vip_pkg):
  - CLOG2 function for counter widths (replaces per-module clogb2).
  - State encoding constants WAIT_FRAME=2'd0, EVEN_LINE=2'd1, ODD_LINE=2'd2.
  - Pipeline latency constant DSCALE2X_LAT=3.
- One sub-module, vip_dscale2x_linebuf:
  - Simple dual-port RAM, WIDTH/2 x 3*(BITS+1).
  - Single clock, one write port, one read port with registered read (1-cycle latency).
  - Read-during-write to the same address is never exercised.

Test Plan:
1. 4x2 frame, enable=1, R row0 = 10,20,30,40 and row1 = 11,21,31,41 (G and B equal R) -> two out_href pulses with R/G/B = 16 then 36; each pulse lands 3 cycles after input x=1 and x=3 of row1.
2. 4x2 frame of all 255, then all 0, enable=1 -> outputs 255,255 then 0,0; no overflow or wrap.
3. Odd geometry 5x3, enable=1 -> exactly 2 output pixels, both from rows 0/1; column 4 and row 2 produce nothing.
4. enable=0, 8x4 ramp (value = x+8y) -> out_href/out_data equal the input delayed 3 cycles, 32 pixels bit-exact; enable toggled to 1 mid-frame -> no change until the next frame, then 2x2 averaging starts.
5. rst pulsed high for 1 cycle during row1 of a 4x2 frame -> outputs 0 immediately; remaining pixels of that frame are ignored; the next frame downscales correctly (rerun scenario 1 values).
6. Line of WIDTH+4 pixels at WIDTH=8 -> only 4 output pixels per odd line; no buffer write at address >= 4 (assertion on the write address).
